// File: rtl/slice_word_packer.sv
// slice_word_packer: pairs consecutive 16-bit slices into 32-bit words
// (first slice in the low half) and buffers them in a small first-word-
// fall-through FIFO. The input side never stalls; a push that finds the
// FIFO full is dropped and recorded in a sticky overflow flag.
//
// Output handshake: word_o/half_o are meaningful whenever word_valid_o=1.
// A word is transferred on a rising clk_i edge where word_valid_o=1 and
// word_ready_i=1. While word_ready_i=0, word_valid_o stays high and
// word_o/half_o hold their value. word_valid_o never depends on
// word_ready_i.
module slice_word_packer #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [15:0]   slice_i,
    input  logic          slice_valid_i,
    input  logic          flush_i,
    output logic [31:0]   word_o,
    output logic          half_o,
    output logic          word_valid_o,
    input  logic          word_ready_i,
    output logic [CW-1:0] count_o,
    output logic          pending_o,
    output logic          overflow_o
);

    localparam int PW = CW - 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Pack register
    logic [15:0]   low_q;
    logic          pending_q;

    // FIFO state
    logic [32:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    // Next-state / push request from the packer
    logic [15:0]   low_d;
    logic          pending_d;
    logic          push_req;
    logic [31:0]   push_word;
    logic          push_half;

    // FIFO control
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          fifo_empty;

    // Packer: the slice is applied first, then flush looks at the resulting
    // pending state, so a same-cycle slice that became the low half is
    // flushed out as a half word, while a completed pair suppresses flush.
    always_comb begin
        low_d     = low_q;
        pending_d = pending_q;
        push_req  = 1'b0;
        push_word = 32'h0;
        push_half = 1'b0;

        if (slice_valid_i) begin
            if (!pending_q) begin
                low_d     = slice_i;
                pending_d = 1'b1;
            end else begin
                push_req  = 1'b1;
                push_word = {slice_i, low_q};
                pending_d = 1'b0;
            end
        end

        if (flush_i && pending_d) begin
            push_req  = 1'b1;
            push_word = {16'h0, low_d};
            push_half = 1'b1;
            pending_d = 1'b0;
        end
    end

    // FIFO accept/drop decision: a full FIFO still accepts if the head
    // leaves in the same cycle, since the freed slot is the one written.
    always_comb begin
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && word_ready_i;
        push_ok    = push_req && ((count_q != FULL_COUNT) || pop);
        drop       = push_req && !push_ok;
    end

    // Pack register update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            low_q     <= 16'h0;
            pending_q <= 1'b0;
        end else begin
            low_q     <= low_d;
            pending_q <= pending_d;
        end
    end

    // FIFO storage; contents need no reset because the read side is gated
    // by count.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wr_ptr_q] <= {push_half, push_word};
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head-of-FIFO read, forced to zero when empty
    always_comb begin
        word_o       = 32'h0;
        half_o       = 1'b0;
        word_valid_o = !fifo_empty;
        if (!fifo_empty) begin
            word_o = mem_q[rd_ptr_q][31:0];
            half_o = mem_q[rd_ptr_q][32];
        end
        count_o    = count_q;
        pending_o  = pending_q;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_slice_word_packer.sv
// Directed testbench for slice_word_packer (DEPTH=4).
module tb_slice_word_packer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [15:0]   slice_i = 16'h0;
    logic          slice_valid_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [31:0]   word_o;
    logic          half_o;
    logic          word_valid_o;
    logic          word_ready_i = 1'b0;
    logic [CW-1:0] count_o;
    logic          pending_o;
    logic          overflow_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    slice_word_packer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .slice_i       (slice_i),
        .slice_valid_i (slice_valid_i),
        .flush_i       (flush_i),
        .word_o        (word_o),
        .half_o        (half_o),
        .word_valid_o  (word_valid_o),
        .word_ready_i  (word_ready_i),
        .count_o       (count_o),
        .pending_o     (pending_o),
        .overflow_o    (overflow_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic drive(input logic v, input logic [15:0] s, input logic f);
        slice_valid_i = v;
        slice_i       = s;
        flush_i       = f;
        @(posedge clk_i);
        #1;
        slice_valid_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (word_o !== 32'h0) begin bad++; $display("FAIL rst_word got=%h exp=0", word_o); end
        total++; if (half_o !== 1'b0) begin bad++; $display("FAIL rst_half got=%b exp=0", half_o); end
        total++; if (word_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", word_valid_o); end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count_o); end
        total++; if (pending_o !== 1'b0) begin bad++; $display("FAIL rst_pending got=%b exp=0", pending_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow_o); end
    endtask

    task automatic test_pairing();
        word_ready_i = 1'b1;
        drive(1'b1, 16'h1111, 1'b0);
        total++; if (pending_o !== 1'b1) begin bad++; $display("FAIL pair_pending got=%b exp=1", pending_o); end
        total++; if (word_valid_o !== 1'b0) begin bad++; $display("FAIL pair_valid_early got=%b exp=0", word_valid_o); end
        drive(1'b1, 16'h2222, 1'b0);
        total++; if (word_valid_o !== 1'b1) begin bad++; $display("FAIL pair_valid got=%b exp=1", word_valid_o); end
        total++; if (word_o !== 32'h22221111) begin bad++; $display("FAIL pair_word got=%h exp=22221111", word_o); end
        total++; if (half_o !== 1'b0) begin bad++; $display("FAIL pair_half got=%b exp=0", half_o); end
        total++; if (count_o !== 3'd1) begin bad++; $display("FAIL pair_count got=%0d exp=1", count_o); end
        total++; if (pending_o !== 1'b0) begin bad++; $display("FAIL pair_pending_clr got=%b exp=0", pending_o); end
        drive(1'b0, 16'h0, 1'b0);
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL pair_count_drain got=%0d exp=0", count_o); end
        total++; if (word_valid_o !== 1'b0) begin bad++; $display("FAIL pair_valid_drain got=%b exp=0", word_valid_o); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        do_reset();
        word_ready_i = 1'b0;
        exp_q = {32'h00020001, 32'h00040003, 32'h00060005, 32'h00080007};
        for (int i = 1; i <= 10; i++) drive(1'b1, 16'(i), 1'b0);
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", count_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
        total++; if (pending_o !== 1'b0) begin bad++; $display("FAIL ovf_pending got=%b exp=0", pending_o); end
        // Holding ready low must keep the head stable.
        drive(1'b0, 16'h0, 1'b0);
        total++; if (word_o !== 32'h00020001) begin bad++; $display("FAIL ovf_hold got=%h exp=00020001", word_o); end
        word_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = exp_q.pop_front();
            total++; if (word_valid_o !== 1'b1) begin bad++; $display("FAIL ovf_drain_valid%0d got=%b exp=1", k, word_valid_o); end
            total++; if (word_o !== exp) begin bad++; $display("FAIL ovf_drain_word%0d got=%h exp=%h", k, word_o, exp); end
            drive(1'b0, 16'h0, 1'b0);
        end
        total++; if (word_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", word_valid_o); end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL ovf_empty_count got=%0d exp=0", count_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp;
        do_reset();
        word_ready_i = 1'b0;
        for (int i = 'h11; i <= 'h18; i++) drive(1'b1, 16'(i), 1'b0);
        drive(1'b1, 16'hAAAA, 1'b0);
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fp_count_pre got=%0d exp=4", count_o); end
        word_ready_i = 1'b1;
        drive(1'b1, 16'hBBBB, 1'b0);
        word_ready_i = 1'b0;
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fp_count got=%0d exp=4", count_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%b exp=0", overflow_o); end
        exp_q = {32'h00140013, 32'h00160015, 32'h00180017, 32'hBBBBAAAA};
        word_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = exp_q.pop_front();
            total++; if (word_o !== exp) begin bad++; $display("FAIL fp_drain_word%0d got=%h exp=%h", k, word_o, exp); end
            drive(1'b0, 16'h0, 1'b0);
        end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL fp_empty got=%0d exp=0", count_o); end
    endtask

    task automatic test_flush();
        word_ready_i = 1'b0;
        drive(1'b1, 16'hABCD, 1'b0);
        drive(1'b0, 16'h0, 1'b1);
        total++; if (word_o !== 32'h0000ABCD) begin bad++; $display("FAIL fl_word got=%h exp=0000abcd", word_o); end
        total++; if (half_o !== 1'b1) begin bad++; $display("FAIL fl_half got=%b exp=1", half_o); end
        total++; if (count_o !== 3'd1) begin bad++; $display("FAIL fl_count got=%0d exp=1", count_o); end
        total++; if (pending_o !== 1'b0) begin bad++; $display("FAIL fl_pending got=%b exp=0", pending_o); end
        drive(1'b0, 16'h0, 1'b1);
        total++; if (count_o !== 3'd1) begin bad++; $display("FAIL fl_empty_flush got=%0d exp=1", count_o); end
        word_ready_i = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL fl_drain got=%0d exp=0", count_o); end
    endtask

    task automatic test_slice_flush();
        word_ready_i = 1'b0;
        drive(1'b1, 16'h1234, 1'b0);
        drive(1'b1, 16'h5678, 1'b1);
        total++; if (count_o !== 3'd1) begin bad++; $display("FAIL sf_pair_count got=%0d exp=1", count_o); end
        total++; if (word_o !== 32'h56781234) begin bad++; $display("FAIL sf_pair_word got=%h exp=56781234", word_o); end
        total++; if (half_o !== 1'b0) begin bad++; $display("FAIL sf_pair_half got=%b exp=0", half_o); end
        drive(1'b1, 16'h9999, 1'b1);
        total++; if (count_o !== 3'd2) begin bad++; $display("FAIL sf_half_count got=%0d exp=2", count_o); end
        total++; if (pending_o !== 1'b0) begin bad++; $display("FAIL sf_half_pending got=%b exp=0", pending_o); end
        word_ready_i = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        word_ready_i = 1'b0;
        total++; if (word_o !== 32'h00009999) begin bad++; $display("FAIL sf_half_word got=%h exp=00009999", word_o); end
        total++; if (half_o !== 1'b1) begin bad++; $display("FAIL sf_half_flag got=%b exp=1", half_o); end
        word_ready_i = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL sf_drain got=%0d exp=0", count_o); end
    endtask

    task automatic test_reset_mid();
        word_ready_i = 1'b0;
        for (int i = 1; i <= 10; i++) drive(1'b1, 16'(i), 1'b0);
        word_ready_i = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        word_ready_i = 1'b0;
        drive(1'b1, 16'h7777, 1'b0);
        total++; if ({pending_o, count_o, overflow_o} !== {1'b1, 3'd3, 1'b1}) begin
            bad++; $display("FAIL rm_pre got=p%b c%0d o%b exp=p1 c3 o1", pending_o, count_o, overflow_o);
        end
        do_reset();
        total++; if ({word_o, half_o, word_valid_o, count_o, pending_o, overflow_o} !== 38'h0) begin
            bad++; $display("FAIL rm_cleared got=w%h h%b v%b c%0d p%b o%b exp=all0", word_o, half_o, word_valid_o, count_o, pending_o, overflow_o);
        end
        drive(1'b1, 16'h3333, 1'b0);
        drive(1'b1, 16'h4444, 1'b0);
        total++; if (word_o !== 32'h44443333) begin bad++; $display("FAIL rm_word got=%h exp=44443333", word_o); end
        total++; if (count_o !== 3'd1) begin bad++; $display("FAIL rm_count got=%0d exp=1", count_o); end
        total++; if (half_o !== 1'b0) begin bad++; $display("FAIL rm_half got=%b exp=0", half_o); end
    endtask

    initial begin
        #2;
        test_reset();
        test_pairing();
        test_overflow();
        test_full_pop();
        test_flush();
        test_slice_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
